// File: rtl/cycle_counter_pkg.sv
// Shared constants and types for the cycle counter.
// Build option: CYCLE_COUNTER_SATURATE_EN makes the counter stop at all-ones
// instead of wrapping to zero.
package cycle_counter_pkg;

  localparam int unsigned CC_WIDTH_DEFAULT = 32;
  localparam int unsigned CC_DEPTH_DEFAULT = 3;

  // Next-state select for the count register.
  typedef enum logic [1:0] {
    CTR_HOLD  = 2'd0,
    CTR_INC   = 2'd1,
    CTR_CLEAR = 2'd2
  } ctr_sel_e;

endpackage

// File: rtl/cycle_counter_dff_chain.sv
// Shift chain of width_p-bit flops with a synchronous set-to-all-ones input.
// The input d enters stage 0 and q is the last stage.
// With num_stages_p = 0 the chain collapses to a wire from d to q.
module cycle_counter_dff_chain #(
  parameter int unsigned width_p      = 1,
  parameter int unsigned num_stages_p = 3
) (
  input  logic               clk,
  input  logic               set,
  input  logic [width_p-1:0] d,
  output logic [width_p-1:0] q
);

  if (num_stages_p == 0) begin : g_pass
    // No stages: clk and set have no effect. They are folded into a dummy
    // signal only so that the ports do not appear unused.
    logic unused_ok;
    assign unused_ok = ^{clk, set};
    assign q = d;
  end else begin : g_chain
    logic [num_stages_p-1:0][width_p-1:0] stage_reg;

    // Set forces every stage to all-ones; otherwise shift d toward q.
    always_ff @(posedge clk) begin
      if (set) begin
        stage_reg <= '1;
      end else begin
        stage_reg[0] <= d;
        for (int i = 1; i < int'(num_stages_p); i++) begin
          stage_reg[i] <= stage_reg[i-1];
        end
      end
    end

    assign q = stage_reg[num_stages_p-1];
  end

endmodule

// File: rtl/cycle_counter.sv
// Free-running cycle counter with a reset-delay chain and a snapshot register.
// reset_o is a delayed active-high reset. The count and the snapshot are held
// in reset until reset_o releases.
// Build option: CYCLE_COUNTER_SATURATE_EN makes the counter saturate at
// all-ones; without it the counter wraps to zero.
module cycle_counter
  import cycle_counter_pkg::*;
#(
  parameter int unsigned width_p       = CC_WIDTH_DEFAULT,
  parameter int unsigned reset_depth_p = CC_DEPTH_DEFAULT
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               capture_i,
  output logic               reset_o,
  output logic [width_p-1:0] ctr_r_o,
  output logic [width_p-1:0] snap_r_o,
  output logic               snap_v_o
);

  logic               reset_req;
  logic               chain_q;
  logic               rst_int;
  ctr_sel_e           ctr_sel;
  logic [width_p-1:0] ctr_reg;
  logic [width_p-1:0] ctr_next;
  logic [width_p-1:0] snap_reg;
  logic               snap_v_reg;

  assign reset_req = ~reset_n_i;

  // The chain input is ~reset_n_i, which is 0 whenever the chain is not being
  // set. Zeros therefore shift in after release. With zero stages the chain is
  // a wire, so reset_o becomes ~reset_n_i.
  cycle_counter_dff_chain #(
    .width_p      (1),
    .num_stages_p (reset_depth_p)
  ) u_chain (
    .clk (clk_i),
    .set (reset_req),
    .d   (reset_req),
    .q   (chain_q)
  );

  assign reset_o = chain_q;
  assign rst_int = reset_req | chain_q;

  // Choose the next count. Clear beats enable, and reset is applied in the
  // register itself.
  always_comb begin
    ctr_sel = CTR_HOLD;
    if (clear_i) begin
      ctr_sel = CTR_CLEAR;
    end else if (en_i) begin
`ifdef CYCLE_COUNTER_SATURATE_EN
      if (!(&ctr_reg)) begin
        ctr_sel = CTR_INC;
      end
`else
      ctr_sel = CTR_INC;
`endif
    end
  end

  // Decode the select into the next count value. The increment wraps naturally.
  always_comb begin
    ctr_next = ctr_reg;
    case (ctr_sel)
      CTR_CLEAR: ctr_next = '0;
      CTR_INC:   ctr_next = ctr_reg + width_p'(1);
      default:   ctr_next = ctr_reg;
    endcase
  end

  // Count register, held at zero while the internal reset is active.
  always_ff @(posedge clk_i) begin
    if (rst_int) begin
      ctr_reg <= '0;
    end else begin
      ctr_reg <= ctr_next;
    end
  end

  // Snapshot latches the count from before this edge. Valid stays set until
  // the next reset.
  always_ff @(posedge clk_i) begin
    if (rst_int) begin
      snap_reg   <= '0;
      snap_v_reg <= 1'b0;
    end else if (capture_i) begin
      snap_reg   <= ctr_reg;
      snap_v_reg <= 1'b1;
    end
  end

  assign ctr_r_o  = ctr_reg;
  assign snap_r_o = snap_reg;
  assign snap_v_o = snap_v_reg;

endmodule

// File: tb/tb_cycle_counter.sv
// Directed self-checking bench for cycle_counter. It uses three instances:
// the default configuration (32 bits, 3 stages), a 4-bit instance for the
// wrap/saturate check, and a zero-depth instance.
module tb_cycle_counter;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic clear;
  logic capture;
  logic en_w4;
  logic en_d0;

  logic        rst_o;
  logic [31:0] ctr;
  logic [31:0] snap;
  logic        snap_v;

  logic        w4_rst_o;
  logic [3:0]  w4_ctr;
  logic [3:0]  w4_snap;
  logic        w4_snap_v;

  logic        d0_rst_o;
  logic [7:0]  d0_ctr;
  logic [7:0]  d0_snap;
  logic        d0_snap_v;

  int total = 0;
  int bad   = 0;
  int edge_n = -100;

  always #5 clk = ~clk;

  cycle_counter #(.width_p(32), .reset_depth_p(3)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .en_i      (en),
    .clear_i   (clear),
    .capture_i (capture),
    .reset_o   (rst_o),
    .ctr_r_o   (ctr),
    .snap_r_o  (snap),
    .snap_v_o  (snap_v)
  );

  cycle_counter #(.width_p(4), .reset_depth_p(3)) dut_w4 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .en_i      (en_w4),
    .clear_i   (1'b0),
    .capture_i (1'b0),
    .reset_o   (w4_rst_o),
    .ctr_r_o   (w4_ctr),
    .snap_r_o  (w4_snap),
    .snap_v_o  (w4_snap_v)
  );

  cycle_counter #(.width_p(8), .reset_depth_p(0)) dut_d0 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .en_i      (en_d0),
    .clear_i   (1'b0),
    .capture_i (1'b0),
    .reset_o   (d0_rst_o),
    .ctr_r_o   (d0_ctr),
    .snap_r_o  (d0_snap),
    .snap_v_o  (d0_snap_v)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle. edge_n counts edges since release. The
  // 4-bit counter stops being enabled after release edge 19, where it has
  // seen 17 counting edges.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    $display("edge %0d: rst=%0b ctr=%0d snap=%0d v=%0b w4=%0d d0=%0d",
             edge_n, rst_o, ctr, snap, snap_v, w4_ctr, d0_ctr);
    if (edge_n == 19) en_w4 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; clear = 1'b0; capture = 1'b0;
    en_w4 = 1'b1; en_d0 = 1'b1;

    repeat (5) step();
    chk("rst_reset_o", {31'b0, rst_o}, 32'd1);
    chk("rst_ctr",     ctr,            32'd0);
    chk("rst_snap",    snap,           32'd0);
    chk("rst_snap_v",  {31'b0, snap_v}, 32'd0);
    chk("rst_w4_reset_o", {31'b0, w4_rst_o}, 32'd1);
    chk("rst_d0_reset_o", {31'b0, d0_rst_o}, 32'd1);
    chk("rst_d0_ctr",  {24'b0, d0_ctr}, 32'd0);

    // Release: edge 0 is the first edge that samples reset_n = 1.
    reset_n = 1'b1; edge_n = -1;
    step();
    chk("e0_reset_o", {31'b0, rst_o}, 32'd1);
    chk("e0_ctr",     ctr,            32'd0);
    chk("e0_d0_reset_o", {31'b0, d0_rst_o}, 32'd0);
    chk("e0_d0_ctr",  {24'b0, d0_ctr}, 32'd1);
    step();
    chk("e1_reset_o", {31'b0, rst_o}, 32'd1);
    chk("e1_ctr",     ctr,            32'd0);
    step();
    chk("e2_reset_o", {31'b0, rst_o}, 32'd0);
    chk("e2_ctr",     ctr,            32'd0);
    step();
    chk("e3_ctr", ctr, 32'd1);
    step();
    chk("e4_ctr", ctr, 32'd2);
    step();
    chk("e5_ctr", ctr, 32'd3);

    // Enable gating
    en = 1'b0; step();
    chk("gate_hold", ctr, 32'd3);
    en = 1'b1; step();
    chk("gate_inc1", ctr, 32'd4);
    step();
    chk("gate_inc2", ctr, 32'd5);

    // Clear priority over enable at ctr = 10
    repeat (5) step();
    chk("pre_clear_ctr", ctr, 32'd10);
    clear = 1'b1; step();
    chk("clear_ctr", ctr, 32'd0);
    clear = 1'b0; step();
    chk("post_clear_ctr", ctr, 32'd1);

    // Get to ctr = 7 (edge 21). The 4-bit counter has been frozen since edge 19.
    repeat (6) step();
    chk("pre_cap_ctr", ctr, 32'd7);
`ifdef CYCLE_COUNTER_SATURATE_EN
    chk("w4_saturate", {28'b0, w4_ctr}, 32'd15);
`else
    chk("w4_wrap",     {28'b0, w4_ctr}, 32'd1);
`endif

    // Capture together with clear
    capture = 1'b1; clear = 1'b1; step();
    chk("capclr_snap",   snap,             32'd7);
    chk("capclr_snap_v", {31'b0, snap_v},  32'd1);
    chk("capclr_ctr",    ctr,              32'd0);
    capture = 1'b0; clear = 1'b0; step();
    chk("post_cap_ctr",  ctr,  32'd1);
    chk("post_cap_snap", snap, 32'd7);
    step();
    capture = 1'b1; step();
    chk("cap2_snap", snap, 32'd2);
    chk("cap2_ctr",  ctr,  32'd3);
    capture = 1'b0;

    // Run to ctr = 50 (edge 72)
    repeat (47) step();
    chk("pre_mid_ctr", ctr, 32'd50);
    chk("pre_mid_d0_ctr", {24'b0, d0_ctr}, 32'd73);

    // Single-cycle reset pulse in the middle of operation
    reset_n = 1'b0; step();
    chk("mid_reset_o", {31'b0, rst_o},  32'd1);
    chk("mid_ctr",     ctr,             32'd0);
    chk("mid_snap",    snap,            32'd0);
    chk("mid_snap_v",  {31'b0, snap_v}, 32'd0);
    chk("mid_d0_reset_o", {31'b0, d0_rst_o}, 32'd1);
    chk("mid_d0_ctr",  {24'b0, d0_ctr}, 32'd0);
    reset_n = 1'b1; step();
    chk("rr0_reset_o", {31'b0, rst_o}, 32'd1);
    chk("rr0_ctr",     ctr,            32'd0);
    chk("rr0_d0_ctr",  {24'b0, d0_ctr}, 32'd1);
    step();
    chk("rr1_reset_o", {31'b0, rst_o}, 32'd1);
    step();
    chk("rr2_reset_o", {31'b0, rst_o}, 32'd0);
    chk("rr2_ctr",     ctr,            32'd0);
    step();
    chk("rr3_ctr", ctr, 32'd1);
    step();
    chk("rr4_ctr", ctr, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
